// File: rtl/bounded_counter_updown_pkg.sv
// -----------------------------------------------------------------------------
// bounded_counter_updown_pkg
// Shared definitions for the bounded up/down counter and its step calculator.
//   mode_e    : boundary behaviour selector (wrap / saturate / bounce / reserved)
//   DIR_UP    : direction constant for counting upward
//   DIR_DOWN  : direction constant for counting downward
// -----------------------------------------------------------------------------
package bounded_counter_updown_pkg;

  // The reserved encoding is kept in the enum so every 2-bit value has a name;
  // the step calculator treats it exactly like saturate.
  typedef enum logic [1:0] {
    MODE_WRAP   = 2'b00,
    MODE_SAT    = 2'b01,
    MODE_BOUNCE = 2'b10,
    MODE_RSVD   = 2'b11
  } mode_e;

  localparam logic DIR_UP   = 1'b1;
  localparam logic DIR_DOWN = 1'b0;

endpackage

// File: rtl/bounded_step_calc.sv
// -----------------------------------------------------------------------------
// bounded_step_calc
// Purely combinational next-value calculator for the bounded counter.
// Works in WIDTH+1 bits so that neither an overflow past MAX_VAL nor an
// underflow below MIN_VAL can silently wrap through the register width.
//   i_count        : current counter value
//   i_step         : step magnitude (0 means hold)
//   i_dir          : direction to apply this cycle (DIR_UP / DIR_DOWN)
//   i_mode         : boundary mode (wrap / saturate / bounce / reserved)
//   o_nextCount    : value the counter takes if this step is applied
//   o_boundaryHit  : the step would have left [MIN_VAL, MAX_VAL]
//   o_flip         : bounce mode only, the stored direction must reverse
// -----------------------------------------------------------------------------
module bounded_step_calc
  import bounded_counter_updown_pkg::*;
#(
  parameter int WIDTH   = 8,
  parameter int MIN_VAL = 10,
  parameter int MAX_VAL = 40,
  parameter int STEP_W  = 4
) (
  input  logic [WIDTH-1:0]  i_count,
  input  logic [STEP_W-1:0] i_step,
  input  logic              i_dir,
  input  logic [1:0]        i_mode,
  output logic [WIDTH-1:0]  o_nextCount,
  output logic              o_boundaryHit,
  output logic              o_flip
);

  localparam logic [WIDTH:0]   MinExt = (WIDTH+1)'(MIN_VAL);
  localparam logic [WIDTH:0]   MaxExt = (WIDTH+1)'(MAX_VAL);
  localparam logic [WIDTH-1:0] MinW   = WIDTH'(MIN_VAL);
  localparam logic [WIDTH-1:0] MaxW   = WIDTH'(MAX_VAL);

  logic [WIDTH:0]   w_stepExt;
  logic [WIDTH:0]   w_sum;
  logic [WIDTH:0]   w_lowLimit;
  logic [WIDTH-1:0] w_diff;

  // Underflow is tested as count < MIN_VAL + step rather than by looking at a
  // borrow, so a subtraction that would pass through zero is still caught.
  assign w_stepExt  = {{(WIDTH+1-STEP_W){1'b0}}, i_step};
  assign w_sum      = {1'b0, i_count} + w_stepExt;
  assign w_lowLimit = MinExt + w_stepExt;
  assign w_diff     = i_count - w_stepExt[WIDTH-1:0];

  // Pick the next value. Landing exactly on a bound is an ordinary step; only
  // a step that would go beyond the bound is a boundary event. Bounce clamps
  // to the bound it ran into and asks the top level to reverse direction.
  always_comb begin
    o_nextCount   = i_count;
    o_boundaryHit = 1'b0;
    o_flip        = 1'b0;
    if (i_dir == DIR_UP) begin
      if (w_sum > MaxExt) begin
        o_boundaryHit = 1'b1;
        case (i_mode)
          MODE_WRAP:   o_nextCount = MinW;
          MODE_BOUNCE: begin
            o_nextCount = MaxW;
            o_flip      = 1'b1;
          end
          default:     o_nextCount = MaxW;
        endcase
      end else begin
        o_nextCount = w_sum[WIDTH-1:0];
      end
    end else begin
      if ({1'b0, i_count} < w_lowLimit) begin
        o_boundaryHit = 1'b1;
        case (i_mode)
          MODE_WRAP:   o_nextCount = MaxW;
          MODE_BOUNCE: begin
            o_nextCount = MinW;
            o_flip      = 1'b1;
          end
          default:     o_nextCount = MinW;
        endcase
      end else begin
        o_nextCount = w_diff;
      end
    end
  end

endmodule

// File: rtl/bounded_counter_updown.sv
// -----------------------------------------------------------------------------
// bounded_counter_updown
// Up/down counter confined to [MIN_VAL, MAX_VAL] with programmable step and
// wrap / saturate / bounce boundary handling.
//   clk, rst   : clock (rising edge), asynchronous active-high reset
//   en         : count enable
//   load       : synchronous load of data, wins over en
//   data       : load value, clamped into range (load_err flags a clamp)
//   u_d        : direction request, 1 = up; bounce samples it only on load
//   step       : step magnitude, 0 holds the count
//   mode       : 00 wrap, 01 saturate, 10 bounce, 11 behaves as saturate
//   count      : registered counter value
//   dir        : effective direction (u_d, or stored direction in bounce)
//   at_min     : count == MIN_VAL
//   at_max     : count == MAX_VAL
//   tc         : one-cycle registered pulse on a boundary event
//   load_err   : one-cycle registered pulse on an out-of-range load
// -----------------------------------------------------------------------------
module bounded_counter_updown
  import bounded_counter_updown_pkg::*;
#(
  parameter int WIDTH   = 8,
  parameter int MIN_VAL = 10,
  parameter int MAX_VAL = 40,
  parameter int STEP_W  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              load,
  input  logic [WIDTH-1:0]  data,
  input  logic              u_d,
  input  logic [STEP_W-1:0] step,
  input  logic [1:0]        mode,
  output logic [WIDTH-1:0]  count,
  output logic              dir,
  output logic              at_min,
  output logic              at_max,
  output logic              tc,
  output logic              load_err
);

  localparam logic [WIDTH-1:0] MinW = WIDTH'(MIN_VAL);
  localparam logic [WIDTH-1:0] MaxW = WIDTH'(MAX_VAL);

  // Refuse to elaborate a range that is empty, inverted or does not fit in
  // WIDTH bits, and a step wider than the counter itself.
  if (!(MIN_VAL >= 0 && MIN_VAL < MAX_VAL && (MAX_VAL >> WIDTH) == 0)) begin : g_badRange
    $error("bounded_counter_updown: need 0 <= MIN_VAL < MAX_VAL <= 2**WIDTH-1");
  end
  if (STEP_W > WIDTH || STEP_W < 1) begin : g_badStep
    $error("bounded_counter_updown: STEP_W must be between 1 and WIDTH");
  end

  logic [WIDTH-1:0] r_count;
  logic             r_dir;
  logic             r_tc;
  logic             r_loadErr;

  logic             w_dir;
  logic [WIDTH-1:0] w_nextCount;
  logic             w_boundaryHit;
  logic             w_flip;
  logic [WIDTH-1:0] w_loadVal;
  logic             w_loadErr;

  // Bounce mode follows its own stored direction; the other modes simply
  // obey the u_d pin every cycle.
  assign w_dir = (mode == MODE_BOUNCE) ? r_dir : u_d;

  bounded_step_calc #(
    .WIDTH   (WIDTH),
    .MIN_VAL (MIN_VAL),
    .MAX_VAL (MAX_VAL),
    .STEP_W  (STEP_W)
  ) u_stepCalc (
    .i_count       (r_count),
    .i_step        (step),
    .i_dir         (w_dir),
    .i_mode        (mode),
    .o_nextCount   (w_nextCount),
    .o_boundaryHit (w_boundaryHit),
    .o_flip        (w_flip)
  );

  // Clamp a load value into range so the counter can never hold an illegal
  // value, and remember whether clamping was needed for load_err.
  always_comb begin
    w_loadVal = data;
    w_loadErr = 1'b0;
    if (data < MinW) begin
      w_loadVal = MinW;
      w_loadErr = 1'b1;
    end else if (data > MaxW) begin
      w_loadVal = MaxW;
      w_loadErr = 1'b1;
    end
  end

  // State update with priority reset > load > en > hold. tc and load_err are
  // pulses, so every branch that is not producing one drives them low. The
  // stored direction only changes on a load or on a bounce reversal, which
  // keeps it intact across mode changes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count   <= MinW;
      r_dir     <= DIR_UP;
      r_tc      <= 1'b0;
      r_loadErr <= 1'b0;
    end else if (load) begin
      r_count   <= w_loadVal;
      r_dir     <= u_d;
      r_tc      <= 1'b0;
      r_loadErr <= w_loadErr;
    end else if (en) begin
      r_count   <= w_nextCount;
      if (w_flip) begin
        r_dir <= ~r_dir;
      end
      r_tc      <= w_boundaryHit;
      r_loadErr <= 1'b0;
    end else begin
      r_tc      <= 1'b0;
      r_loadErr <= 1'b0;
    end
  end

  assign count    = r_count;
  assign dir      = w_dir;
  assign at_min   = (r_count == MinW);
  assign at_max   = (r_count == MaxW);
  assign tc       = r_tc;
  assign load_err = r_loadErr;

endmodule
